// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
//
// UART receive front end. Synchronises the asynchronous rx_pin, times each
// bit from the detected start edge, and samples every bit at mid-bit with a
// 2-of-3 majority vote. A good byte is presented on rx_data with a one-cycle
// rx_data_valid strobe. Bad stop bits and parity mismatches raise one-cycle
// error strobes and never update rx_data.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : frames are 8E1 (8 data bits, even parity, 1 stop bit) and
//               parity_err is live.
//   undefined : frames are 8N1 and parity_err is constant 0.
//
// Parameters:
//   CLK_FRE        clock frequency in MHz
//   BAUD_RATE      line rate in bit/s
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   rx_pin         asynchronous serial input, idles high
//   rx_data        last good byte (LSB received first), held until next one
//   rx_data_valid  one-cycle strobe when rx_data is updated
//   frame_err      one-cycle strobe on a low stop bit
//   parity_err     one-cycle strobe on a parity mismatch
//   rx_busy        high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_sampler #(
    parameter int CLK_FRE   = 200,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_busy
);

    localparam int BIT_CYC = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int HALF    = BIT_CYC / 2;
    localparam int CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SMP0 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_SMP1 = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(HALF + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Synchroniser chain plus the delayed copy used for edge detection.
    logic rx_m;
    logic rx_s;
    logic rx_d;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       idx;
    logic [2:0]       idx_nxt;
    logic [7:0]       shreg;
    logic [7:0]       shreg_nxt;
    logic [7:0]       data_nxt;
    logic             valid_nxt;
    logic             ferr_nxt;
    logic             smp_a;
    logic             smp_b;

    logic start_edge;
    logic at_vote;
    logic at_last;
    logic vote;
    logic parity_bad;

    assign start_edge = rx_d & ~rx_s;
    assign at_vote    = (cnt == CNT_VOTE);
    assign at_last    = (cnt == CNT_LAST);
    // The third sample is the live synchronised value at the vote count.
    assign vote       = majority3(smp_a, smp_b, rx_s);

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic par_nxt;
    logic perr_nxt;
    // Even parity: data bits plus parity bit must hold an even count of ones.
    assign parity_bad = ^{shreg, par_bit};
`else
    assign parity_bad = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        data_nxt  = rx_data;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nxt   = par_bit;
        perr_nxt  = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (start_edge) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (at_vote && vote) begin
                    // Start bit did not hold low through mid-bit: glitch.
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (at_last) begin
                    state_nxt = ST_DATA;
                    cnt_nxt   = '0;
                    idx_nxt   = 3'd0;
                end
            end
            ST_DATA: begin
                if (at_vote) begin
                    shreg_nxt = {vote, shreg[7:1]};
                end
                if (at_last) begin
                    cnt_nxt = '0;
                    idx_nxt = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (at_vote) begin
                    par_nxt = vote;
                end
                if (at_last) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Resolve at mid stop bit so back-to-back frames keep half a
                // bit of margin.
                if (at_vote) begin
                    cnt_nxt = '0;
                    if (vote) begin
                        if (parity_bad) begin
`ifdef UART_RX_PARITY_EN
                            perr_nxt = 1'b1;
`endif
                        end else begin
                            valid_nxt = 1'b1;
                            data_nxt  = shreg;
                        end
                        // A start edge arriving this very cycle must not be lost.
                        state_nxt = start_edge ? ST_START : ST_IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_nxt  = parity_bad;
`endif
                        state_nxt = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Held-low line: wait for the idle level before re-arming.
                cnt_nxt = '0;
                if (rx_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m          <= 1'b1;
            rx_s          <= 1'b1;
            rx_d          <= 1'b1;
            state         <= ST_IDLE;
            cnt           <= '0;
            idx           <= 3'd0;
            shreg         <= 8'h00;
            smp_a         <= 1'b1;
            smp_b         <= 1'b1;
            rx_data       <= 8'h00;
            rx_data_valid <= 1'b0;
            frame_err     <= 1'b0;
            rx_busy       <= 1'b0;
        end else begin
            rx_m          <= rx_pin;
            rx_s          <= rx_m;
            rx_d          <= rx_s;
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            idx           <= idx_nxt;
            shreg         <= shreg_nxt;
            if (cnt == CNT_SMP0) begin
                smp_a <= rx_s;
            end
            if (cnt == CNT_SMP1) begin
                smp_b <= rx_s;
            end
            rx_data       <= data_nxt;
            rx_data_valid <= valid_nxt;
            frame_err     <= ferr_nxt;
            rx_busy       <= (state_nxt != ST_IDLE);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bit    <= par_nxt;
            parity_err <= perr_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_sampler
//
// Scoreboard bench for uart_rx_sampler at CLK_FRE=16, BAUD_RATE=1000000
// (16 clocks per bit). Stimulus tasks serialise whole frames onto rx_pin and
// push the frame-level expected outcome into a queue; a monitor on the
// falling edge pops and compares every strobe the receiver produces.
// Honours UART_RX_PARITY_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_uart_rx_sampler;

    localparam int BIT = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBODY = 10;
`else
    localparam int NBODY = 9;
`endif
    // Pin start edge to visible strobe: sync + body bits + half stop bit + vote.
    localparam int LAT = 3 + NBODY * BIT + BIT / 2 + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_pin = 1'b1;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       rx_busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // kind = {valid, frame_err, parity_err}; t < 0 means no latency check.
    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         t;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_last = 8'h00;

    uart_rx_sampler #(
        .CLK_FRE  (16),
        .BAUD_RATE(1000000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_pin       (rx_pin),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .frame_err    (frame_err),
        .parity_err   (parity_err),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Frame-level reference: stop bit high + parity good -> byte delivered;
    // stop high + parity bad -> parity error only; stop low -> frame error
    // (plus parity error if bad). rx_data changes only on delivery.
    task automatic expect_frame(input logic [7:0] b, input logic stop,
                                input logic par_ok, input int t);
        exp_t e;
        e.t = t;
        if (stop && par_ok) begin
            e.kind     = 3'b100;
            e.data     = b;
            model_last = b;
        end else if (stop) begin
            e.kind = 3'b001;
            e.data = model_last;
        end else begin
            e.kind = {2'b01, ~par_ok};
            e.data = model_last;
        end
        exp_q.push_back(e);
    endtask

    // Callers are aligned 1 time unit after a rising edge.
    task automatic drive_bit(input logic b);
        rx_pin = b;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic flip_par, input logic timed);
        logic par_ok;
        par_ok = 1'b1;
`ifdef UART_RX_PARITY_EN
        par_ok = ~flip_par;
`endif
        expect_frame(b, stop, par_ok, timed ? cyc + LAT : -1);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ flip_par);
`else
        if (flip_par) rx_pin = 1'b1;
`endif
        drive_bit(stop);
    endtask

    task automatic idle_cycles(input int n);
        rx_pin = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n && (rx_data_valid || frame_err || parity_err)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got v=%0b f=%0b p=%0b data=%0h expected none",
                         rx_data_valid, frame_err, parity_err, rx_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_kind", {29'd0, rx_data_valid, frame_err, parity_err}, {29'd0, e.kind});
                check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                if (e.t >= 0) check("strobe_latency", cyc, e.t);
            end
        end
    end

    initial begin
        int busy_cnt;
        logic fell;
        logic [7:0] b;
        logic stop;
        logic flip;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {rx_data, rx_data_valid, frame_err, parity_err, rx_busy}, 12'h000);
        rst_n = 1'b1;
        idle_cycles(10);

        // Single byte with exact latency.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        idle_cycles(20);

        // Back-to-back stream.
        for (int n = 0; n < 96; n++) send_frame(8'(n), 1'b1, 1'b0, 1'b1);
        idle_cycles(20);

        // Short low glitch on an idle line.
        rx_pin = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_pin = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rx_busy) busy_cnt++;
        end
        check("glitch_busy_short", {31'd0, (busy_cnt > 0) && (busy_cnt < BIT)}, 32'd1);
        idle_cycles(5);

        // Bad stop bit followed by a held-low line.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        rx_pin = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("break_busy_held", {31'd0, rx_busy}, 32'd1);
        rx_pin = 1'b1;
        fell = 1'b0;
        for (int i = 0; i < 8 && !fell; i++) begin
            @(negedge clk);
            if (!rx_busy) fell = 1'b1;
        end
        check("break_release", {31'd0, fell}, 32'd1);
        idle_cycles(20);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        idle_cycles(10);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        idle_cycles(10);
`endif

        // Randomized frames, occasional bad stop bit or parity.
        for (int n = 0; n < 40; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            flip = ($urandom_range(0, 4) == 0);
            send_frame(b, stop, flip, 1'b1);
            if (!stop) idle_cycles(20);
            idle_cycles($urandom_range(0, 10));
        end
        idle_cycles(20);

        // Reset in the middle of 0xFF (data bit 4), then a clean byte.
        check("queue_empty_before_reset", exp_q.size(), 32'd0);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("midframe_reset_outputs", {rx_data, rx_data_valid, frame_err, parity_err, rx_busy}, 12'h000);
        model_last = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(20);
        send_frame(8'h12, 1'b1, 1'b0, 1'b1);
        idle_cycles(40);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
